// File: rtl/cond_sum_pkg.sv
// Shared types and sizing helpers for the
// pipelined conditional-sum adder.
package cond_sum_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Bit-generate + merge levels + carry-in select
  function automatic int levelsOf(input int w);
    return clog2(w) + 2;
  endfunction

  function automatic int latencyOf(
    input int w,
    input int lps
  );
    return (levelsOf(w) + lps - 1) / lps;
  endfunction

  // Control part of the stage bundle; the
  // per-bit s0/s1/c0/c1 vectors are sized by
  // WIDTH and appended in the top.
  typedef struct packed {
    logic       valid;
    logic       effCin;
    logic [1:0] msbCinPair;
  } stage_ctl_t;

endpackage

// File: rtl/cond_sum_adder_pipe_merge.sv
// One conditional-sum merge level: upper half
// of each 2*BLK group selected by lower carry.
module csa_merge_level
  import cond_sum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 1
) (
  input  logic [WIDTH-1:0] s0,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] c1,
  input  logic [1:0]       msbPair,
  output logic [WIDTH-1:0] s0Sel,
  output logic [WIDTH-1:0] s1Sel,
  output logic [WIDTH-1:0] c0Sel,
  output logic [WIDTH-1:0] c1Sel,
  output logic [1:0]       msbSel
);

  localparam int M  = WIDTH - 2;
  localparam int ML = (M / (2 * BLK)) * 2 * BLK
                      + BLK - 1;

  // c0/c1 at bit i hold the carry out of bit i
  // within its block, so every bit is a prefix
  // result and all of them move with the merge.
  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    localparam int LT = (i / (2 * BLK)) * 2 * BLK
                        + BLK - 1;
    if (((i / BLK) % 2) == 1) begin : gUp
      assign s0Sel[i] = c0[LT] ? s1[i] : s0[i];
      assign s1Sel[i] = c1[LT] ? s1[i] : s0[i];
      assign c0Sel[i] = c0[LT] ? c1[i] : c0[i];
      assign c1Sel[i] = c1[LT] ? c1[i] : c0[i];
    end else begin : gLo
      assign s0Sel[i] = s0[i];
      assign s1Sel[i] = s1[i];
      assign c0Sel[i] = c0[i];
      assign c1Sel[i] = c1[i];
    end
  end

  // Carry out of bit WIDTH-2 rides along for ovf
  if (((M / BLK) % 2) == 1) begin : gMsbUp
    assign msbSel[0] = c0[ML] ? msbPair[1]
                              : msbPair[0];
    assign msbSel[1] = c1[ML] ? msbPair[1]
                              : msbPair[0];
  end else begin : gMsbLo
    assign msbSel = msbPair;
  end

endmodule

// File: rtl/cond_sum_adder_pipe.sv
// Pipelined conditional-sum add/sub with
// valid/ready handshakes and global stall.
module cond_sum_adder_pipe
  import cond_sum_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int LVL_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = levelsOf(WIDTH);

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
  } stage_t;

  logic             stall;
  logic [WIDTH-1:0] bEff;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign bEff     = sub ? ~b : b;

  for (genvar i = 0; i < LEVELS - 1; i++)
  begin : gLvl
    logic             v;
    logic             e;
    logic [1:0]       mp;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    stage_t           d;
    stage_t           q;

    if (i == 0) begin : gGen
      assign v  = in_valid && in_ready;
      assign e  = sub | cin;
      assign s0 = a ^ bEff;
      assign s1 = ~(a ^ bEff);
      assign c0 = a & bEff;
      assign c1 = a | bEff;
      assign mp = {c1[WIDTH-2], c0[WIDTH-2]};
    end else begin : gMrg
      assign v = gLvl[i-1].q.ctl.valid;
      assign e = gLvl[i-1].q.ctl.effCin;
      csa_merge_level #(
        .WIDTH (WIDTH),
        .BLK   (1 << (i - 1))
      ) uMrg (
        .s0      (gLvl[i-1].q.s0),
        .s1      (gLvl[i-1].q.s1),
        .c0      (gLvl[i-1].q.c0),
        .c1      (gLvl[i-1].q.c1),
        .msbPair (gLvl[i-1].q.ctl.msbCinPair),
        .s0Sel   (s0),
        .s1Sel   (s1),
        .c0Sel   (c0),
        .c1Sel   (c1),
        .msbSel  (mp)
      );
    end

    assign d = {v, e, mp, s0, s1, c0, c1};

    if (((i + 1) % LVL_PER_STAGE) == 0)
    begin : gReg
      // Stage register; the whole pipe freezes
      // together while the output is stalled
      always_ff @(posedge clk) begin
        if (rst)         q <= '0;
        else if (!stall) q <= d;
      end
    end else begin : gPass
      assign q = d;
    end
  end

  stage_t           f;
  logic [WIDTH-1:0] sumN;
  logic             coutN;
  logic             msbC;

  assign f     = gLvl[LEVELS-2].q;
  assign sumN  = f.ctl.effCin ? f.s1 : f.s0;
  assign coutN = f.ctl.effCin ? f.c1[WIDTH-1]
                              : f.c0[WIDTH-1];
  assign msbC  = f.ctl.effCin
               ? f.ctl.msbCinPair[1]
               : f.ctl.msbCinPair[0];

  // Carry-in select level feeds the output regs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= f.ctl.valid;
      sum       <= sumN;
      cout      <= coutN;
      ovf       <= msbC ^ coutN;
    end
  end

endmodule

// File: tb/tb_cond_sum_adder_pipe.sv
// Directed and streaming checks for the
// pipelined conditional-sum adder.
module tb_cond_sum_adder_pipe;

  localparam int LAT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv, ir, ov, ordy, ci, sb, co, of;
  logic [15:0] a, b, s;

  logic        iv8, ir8, ov8, ordy8;
  logic        ci8, sb8, co8, of8;
  logic [7:0]  a8, b8, s8;

  logic        iv64, ir64, ov64, ordy64;
  logic        ci64, sb64, co64, of64;
  logic [63:0] a64, b64, s64;

  cond_sum_adder_pipe #(
    .WIDTH(16), .LVL_PER_STAGE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .a(a), .b(b), .cin(ci), .sub(sb),
    .out_valid(ov), .out_ready(ordy),
    .sum(s), .cout(co), .ovf(of)
  );

  cond_sum_adder_pipe #(
    .WIDTH(8), .LVL_PER_STAGE(5)
  ) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(ci8), .sub(sb8),
    .out_valid(ov8), .out_ready(ordy8),
    .sum(s8), .cout(co8), .ovf(of8)
  );

  cond_sum_adder_pipe #(
    .WIDTH(64), .LVL_PER_STAGE(2)
  ) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .cin(ci64), .sub(sb64),
    .out_valid(ov64), .out_ready(ordy64),
    .sum(s64), .cout(co64), .ovf(of64)
  );

  int nVec = 0;
  int nBad = 0;

  task automatic chk(
    input string       tag,
    input logic [65:0] got,
    input logic [65:0] exp
  );
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [65:0] pk16(
    input logic o, input logic c,
    input logic [15:0] v
  );
    return {o, c, 48'h0, v};
  endfunction

  // Plain wide-add reference; ovf from signs
  function automatic logic [65:0] refAdd(
    input int w,
    input logic [63:0] x, input logic [63:0] y,
    input logic c, input logic m
  );
    logic [63:0] msk, xx, yy, r;
    logic [64:0] t;
    logic        cc, oo;
    msk = (w == 64) ? '1
                    : ((64'd1 << w) - 64'd1);
    xx = x & msk;
    yy = (m ? ~y : y) & msk;
    t  = {1'b0, xx} + {1'b0, yy}
       + {64'd0, (m | c)};
    r  = t[63:0] & msk;
    cc = t[w];
    oo = (xx[w-1] == yy[w-1])
      && (r[w-1] != xx[w-1]);
    return {oo, cc, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(
    input string tag,
    input logic [15:0] x, input logic [15:0] y,
    input logic c, input logic m,
    input logic [15:0] es,
    input logic ec, input logic eo
  );
    int n;
    a = x; b = y; ci = c; sb = m; iv = 1'b1;
    tick;
    iv = 1'b0;
    n = 1;
    while (!ov && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "-lat"}, 66'(n), 66'(LAT));
    chk({tag, "-res"}, pk16(of, co, s),
        pk16(eo, ec, es));
    tick;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  logic [65:0] q8[$];
  logic [65:0] q64[$];
  logic        pat[4];
  logic        stl, pstall, fireIn;
  logic [18:0] held;
  int          sent, got, cyc;

  initial begin
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    iv = 1'b1; a = 16'h1111; b = 16'h2222;
    ci = 1'b0; sb = 1'b0; ordy = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0;
    ci8 = 1'b0; sb8 = 1'b0; ordy8 = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0;
    ci64 = 1'b0; sb64 = 1'b0; ordy64 = 1'b1;

    repeat (3) begin
      tick;
      chk("rst-ov", 66'(ov), 66'(0));
    end
    chk("rst-res", pk16(of, co, s), 66'(0));
    rst = 1'b0;
    iv  = 1'b0;
    #1;
    chk("rst-ready", 66'(ir), 66'(1));
    for (int k = 0; k < LAT; k++) begin
      tick;
      chk("post-rst-ov", 66'(ov), 66'(0));
    end

    runOne("lat", 16'hFFFF, 16'h0001, 0, 0,
           16'h0000, 1, 0);
    runOne("sub1", 16'h8000, 16'h0001, 0, 1,
           16'h7FFF, 1, 1);
    runOne("sub2", 16'h0003, 16'h0005, 0, 1,
           16'hFFFE, 0, 0);
    runOne("ones", 16'hFFFF, 16'hFFFF, 1, 0,
           16'hFFFF, 1, 0);
    runOne("subeq", 16'h1234, 16'h1234, 0, 1,
           16'h0000, 1, 0);
    runOne("povf", 16'h7FFF, 16'h0001, 0, 0,
           16'h8000, 0, 1);
    runOne("cin", 16'h0001, 16'h0002, 1, 0,
           16'h0004, 0, 0);
    runOne("subcin", 16'h0005, 16'h0003, 0, 1,
           16'h0002, 1, 0);

    for (int k = 0; k < 8; k++) begin
      tick;
      chk("idle-ov", 66'(ov), 66'(0));
    end

    sent = 0; got = 0; cyc = 0;
    pstall = 1'b0; held = '0;
    while (got < 10 && cyc < 200) begin
      iv   = (sent < 10);
      a    = 16'(16'h1000 + sent);
      b    = 16'(sent);
      ci   = 1'b0;
      sb   = 1'b0;
      ordy = pat[cyc % 4];
      #1;
      stl = ov && !ordy;
      chk("bp-ready", 66'(ir), 66'(!stl));
      if (pstall)
        chk("bp-hold", 66'({ov, of, co, s}),
            66'(held));
      pstall = stl;
      held   = {ov, of, co, s};
      if (ov && ordy) begin
        chk("bp-data", pk16(of, co, s),
            pk16(0, 0, 16'(16'h1000 + 2 * got)));
        got++;
      end
      fireIn = iv && ir;
      tick;
      if (fireIn) sent++;
      cyc++;
    end
    chk("bp-count", 66'(got), 66'(10));
    iv = 1'b0;
    ordy = 1'b1;
    repeat (LAT + 2) tick;

    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a  = 16'(16'h0A00 + k);
      b  = 16'h0001;
      iv = 1'b1;
      if (k == 2) rst = 1'b1;
      tick;
    end
    rst = 1'b0;
    iv  = 1'b0;
    chk("mrst-ov", 66'(ov), 66'(0));
    runOne("mrst", 16'h0100, 16'h0023, 0, 0,
           16'h0123, 0, 0);

    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 256; y += 5)
        for (int c = 0; c < 2; c++) begin
          if (ov8) begin
            if (q8.size() == 0)
              chk("w8-spurious", 66'(1), 66'(0));
            else
              chk("w8", {of8, co8, 56'h0, s8},
                  q8.pop_front());
          end
          a8  = 8'(x);
          b8  = 8'(y);
          ci8 = c[0];
          sb8 = ((y % 10) == 5);
          iv8 = 1'b1;
          q8.push_back(refAdd(8, 64'(x), 64'(y),
                              c[0], sb8));
          tick;
        end
    iv8 = 1'b0;
    repeat (3) begin
      if (ov8 && q8.size() != 0)
        chk("w8", {of8, co8, 56'h0, s8},
            q8.pop_front());
      tick;
    end
    chk("w8-drain", 66'(q8.size()), 66'(0));

    sent = 0; got = 0; cyc = 0;
    fireIn = 1'b0;
    while (got < 2000 && cyc < 20000) begin
      if (!iv64 || fireIn) begin
        iv64 = (sent < 2000)
            && ($urandom_range(3) != 0);
        a64  = {$urandom, $urandom};
        b64  = {$urandom, $urandom};
        ci64 = 1'($urandom_range(1));
        sb64 = 1'($urandom_range(1));
      end
      ordy64 = 1'($urandom_range(1));
      #1;
      if (ov64 && ordy64) begin
        if (q64.size() == 0)
          chk("w64-spurious", 66'(1), 66'(0));
        else
          chk("w64", {of64, co64, s64},
              q64.pop_front());
        got++;
      end
      fireIn = iv64 && ir64;
      if (fireIn)
        q64.push_back(refAdd(64, a64, b64,
                             ci64, sb64));
      tick;
      if (fireIn) sent++;
      cyc++;
    end
    iv64 = 1'b0;
    chk("w64-count", 66'(got), 66'(2000));

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nBad);
    $finish;
  end

endmodule
